// File: rtl/rgbw_sotp_multi_pkg.sv
// Shared types and constants for the multi-lane RGBW serial transmitter:
// FSM encoding, LED word widths and default bit/latch timing.
package rgbw_sotp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int RGB_BITS  = 24;
  localparam int RGBW_BITS = 32;
  localparam int LANE_BITS = 32;

  localparam int DEF_T0H     = 2;
  localparam int DEF_T0L     = 6;
  localparam int DEF_T1H     = 4;
  localparam int DEF_T1L     = 4;
  localparam int DEF_STR_RST = 7800;

  // Index of the first (most significant) bit sent for the chosen word size.
  function automatic logic [4:0] first_bit(input logic rgbw);
    return rgbw ? 5'(RGBW_BITS - 1) : 5'(RGB_BITS - 1);
  endfunction

endpackage

// File: rtl/rgbw_sotp_multi_if.sv
// FIFO read-side handshake between async_fifo and the transmitter;
// the transmitter uses the master modport, the FIFO the slave modport.
interface rgbw_sotp_multi_if
  import rgbw_sotp_pkg::*;
#(
  parameter int NUM_CH = 2
);
  logic                          in_rd_fifo_empty;
  logic [NUM_CH*LANE_BITS-1:0]   in_rd_fifo_data;
  logic                          out_rd_fifo_en;

  modport master (input in_rd_fifo_empty, input in_rd_fifo_data, output out_rd_fifo_en);
  modport slave  (output in_rd_fifo_empty, output in_rd_fifo_data, input out_rd_fifo_en);
endinterface

// File: rtl/rgbw_sotp_multi_lane_shifter.sv
// One LED lane: MSB-aligned shift register plus registered serial output.
// Define SOTP_OUT_INVERT_EN to invert the output register (idle/latch level 1).
module rgbw_lane_shifter
  import rgbw_sotp_pkg::*;
#(
  parameter int T0H = DEF_T0H,
  parameter int T1H = DEF_T1H,
  parameter int TW  = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 mode,
  input  logic [LANE_BITS-1:0] data,
  input  logic                 active,
  input  logic [TW-1:0]        timer,
  output logic                 sig
);

  logic [LANE_BITS-1:0] shreg_reg, shreg_next;
  logic                 bit_next;
  logic                 high_next;
  logic                 sig_reg;

  // RGB words are left-aligned so the bit on the wire is always bit 31.
  always_comb begin
    shreg_next = shreg_reg;
    if (load) begin
      shreg_next = mode ? data : {data[RGB_BITS-1:0], {(LANE_BITS-RGB_BITS){1'b0}}};
    end else if (shift) begin
      shreg_next = shreg_reg << 1;
    end
    bit_next  = shreg_next[LANE_BITS-1];
    high_next = active && (timer < (bit_next ? TW'(T1H) : TW'(T0H)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_reg <= '0;
`ifdef SOTP_OUT_INVERT_EN
      sig_reg   <= 1'b1;
`else
      sig_reg   <= 1'b0;
`endif
    end else begin
      shreg_reg <= shreg_next;
`ifdef SOTP_OUT_INVERT_EN
      sig_reg   <= ~high_next;
`else
      sig_reg   <= high_next;
`endif
    end
  end

  assign sig = sig_reg;

endmodule

// File: rtl/rgbw_sotp_multi.sv
// Multi-lane SK6812-style transmitter: one FIFO word feeds NUM_CH lanes in
// lockstep. Optional output inversion via SOTP_OUT_INVERT_EN (in the lane shifter).
module rgbw_sotp_multi
  import rgbw_sotp_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int RGBW_T0H       = DEF_T0H,
  parameter int RGBW_T0L       = DEF_T0L,
  parameter int RGBW_T1H       = DEF_T1H,
  parameter int RGBW_T1L       = DEF_T1L,
  parameter int RGBW_STR_RST   = DEF_STR_RST,
  parameter int LEDS_PER_FRAME = 8,
  parameter int COUNTER_MAX    = 7800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_rgbw_mode,
  rgbw_sotp_multi_if.master   fifo,
  output logic [NUM_CH-1:0]   out_sig,
  output logic                out_busy,
  output logic                out_frame_done,
  output logic                out_underrun
);

  localparam int BIT_PERIOD = (RGBW_T0H + RGBW_T0L > RGBW_T1H + RGBW_T1L) ?
                              (RGBW_T0H + RGBW_T0L) : (RGBW_T1H + RGBW_T1L);
  localparam int TW = $clog2(COUNTER_MAX + 1);
  localparam int LW = $clog2(LEDS_PER_FRAME + 1);

  state_t         state_reg, state_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic [4:0]     bit_idx_reg, bit_idx_next;
  logic [LW-1:0]  led_reg, led_next;
  logic           mode_reg, mode_next;
  logic           fetch_reg, fetch_next;
  logic           underrun_reg, underrun_next;
  logic           rd_en, load, shift, prefetch_pt, active_next;

  assign prefetch_pt = (bit_idx_reg == 5'd0) && (led_reg != LW'(LEDS_PER_FRAME - 1));

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    bit_idx_next  = bit_idx_reg;
    led_next      = led_reg;
    mode_next     = mode_reg;
    fetch_next    = fetch_reg;
    underrun_next = underrun_reg;
    rd_en         = 1'b0;
    load          = 1'b0;
    shift         = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        led_next   = '0;
        timer_next = '0;
        if (!fifo.in_rd_fifo_empty) begin
          rd_en      = 1'b1;
          mode_next  = in_rgbw_mode;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load         = 1'b1;
        bit_idx_next = first_bit(mode_reg);
        timer_next   = '0;
        fetch_next   = 1'b0;
        state_next   = ST_SEND;
      end
      ST_SEND: begin
        timer_next = timer_reg + 1'b1;
        // Prefetch one clock ahead so the next word lands on the last low clock.
        if (prefetch_pt && timer_reg == TW'(BIT_PERIOD - 2)) begin
          if (!fifo.in_rd_fifo_empty) begin
            rd_en      = 1'b1;
            fetch_next = 1'b1;
          end else begin
            underrun_next = 1'b1;
            fetch_next    = 1'b0;
          end
        end
        if (timer_reg == TW'(BIT_PERIOD - 1)) begin
          timer_next = '0;
          if (bit_idx_reg != 5'd0) begin
            bit_idx_next = bit_idx_reg - 1'b1;
            shift        = 1'b1;
          end else if (prefetch_pt && fetch_reg) begin
            load         = 1'b1;
            bit_idx_next = first_bit(mode_reg);
            led_next     = led_reg + 1'b1;
          end else begin
            state_next = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        timer_next = timer_reg + 1'b1;
        if (timer_reg == TW'(RGBW_STR_RST - 1)) begin
          timer_next = '0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      bit_idx_reg  <= '0;
      led_reg      <= '0;
      mode_reg     <= 1'b0;
      fetch_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      bit_idx_reg  <= bit_idx_next;
      led_reg      <= led_next;
      mode_reg     <= mode_next;
      fetch_reg    <= fetch_next;
      underrun_reg <= underrun_next;
    end
  end

  assign active_next = (state_next == ST_SEND);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      rgbw_lane_shifter #(
        .T0H (RGBW_T0H),
        .T1H (RGBW_T1H),
        .TW  (TW)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .shift  (shift),
        .mode   (mode_reg),
        .data   (fifo.in_rd_fifo_data[gi*LANE_BITS +: LANE_BITS]),
        .active (active_next),
        .timer  (timer_next),
        .sig    (out_sig[gi])
      );
    end
  endgenerate

  // The FIFO must never be read while reset is held, even with data waiting.
  assign fifo.out_rd_fifo_en = rd_en & rst;
  assign out_busy            = (state_reg != ST_IDLE);
  assign out_frame_done      = (state_reg == ST_LATCH) && (timer_reg == TW'(RGBW_STR_RST - 1));
  assign out_underrun        = underrun_reg;

endmodule
